// File: rtl/sort_result_reader.sv
// rtl/sort_result_reader.sv - captures one sorted frame on sort_valid rise and streams its indices out beat by beat
// Optional checksum beat: define SORT_RESULT_READER_CHECKSUM_EN.

package proj_pkg;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int INDICE_LEN                    = 8;
  localparam int SORTER_POSITION_LEN           = 2;
endpackage

module sort_result_reader #(
  parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
  parameter int POSITION_LEN  = proj_pkg::SORTER_POSITION_LEN
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_smallest_idx,
  input  logic                                     in_sort_valid,
  output logic [INDICE_LEN-1:0]                    out_index,
  output logic [POSITION_LEN-1:0]                  out_position,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     overrun
);

`ifdef SORT_RESULT_READER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, CSUM = 2'd2} state_t;
  // The checksum beat carries the frame's out_last, so slot K-1 does not.
  localparam bit SLOT_LAST_EN = 1'b0;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;
  localparam bit SLOT_LAST_EN = 1'b1;
`endif

  localparam logic [POSITION_LEN-1:0] LAST_POS = POSITION_LEN'(INDICES_COUNT - 1);

  state_t                                   state_q;
  logic                                     sv_q;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] buf_q;
  logic [POSITION_LEN-1:0]                  pos_q;
  logic [POSITION_LEN-1:0]                  pos_d;
  logic [INDICE_LEN-1:0]                    out_index_q;
  logic [POSITION_LEN-1:0]                  out_position_q;
  logic                                     out_valid_q;
  logic                                     out_last_q;
  logic                                     overrun_q;
  logic                                     rise;
  logic                                     accept;

  // sv_q resets high so a level already asserted at reset release is not a new frame.
  assign rise   = in_sort_valid & ~sv_q;
  assign accept = out_valid_q & out_ready;
  assign pos_d  = pos_q + POSITION_LEN'(1);

`ifdef SORT_RESULT_READER_CHECKSUM_EN
  logic [INDICE_LEN-1:0] csum_q;
  logic [INDICE_LEN-1:0] csum_d;

  // XOR of every index in the incoming frame, latched together with the frame.
  always_comb begin
    csum_d = '0;
    for (int i = 0; i < INDICES_COUNT; i++) begin
      csum_d = csum_d ^ in_smallest_idx[i];
    end
  end
`endif

  // Capture/stream FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sv_q           <= 1'b1;
      buf_q          <= '0;
      pos_q          <= '0;
      out_index_q    <= '0;
      out_position_q <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef SORT_RESULT_READER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      sv_q <= in_sort_valid;
      case (state_q)
        IDLE: begin
          if (rise) begin
            buf_q          <= in_smallest_idx;
            pos_q          <= '0;
            out_index_q    <= in_smallest_idx[0];
            out_position_q <= '0;
            out_last_q     <= SLOT_LAST_EN && (LAST_POS == '0);
            out_valid_q    <= 1'b1;
            state_q        <= STREAM;
`ifdef SORT_RESULT_READER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
          end
        end
        STREAM: begin
          // A frame arriving while we still own the previous one is dropped.
          if (rise) begin
            overrun_q <= 1'b1;
          end
          if (accept) begin
            if (pos_q == LAST_POS) begin
`ifdef SORT_RESULT_READER_CHECKSUM_EN
              state_q        <= CSUM;
              out_index_q    <= csum_q;
              out_position_q <= '0;
              out_last_q     <= 1'b1;
`else
              state_q        <= IDLE;
              out_valid_q    <= 1'b0;
              out_last_q     <= 1'b0;
              out_index_q    <= '0;
              out_position_q <= '0;
`endif
            end else begin
              pos_q          <= pos_d;
              out_index_q    <= buf_q[pos_d];
              out_position_q <= pos_d;
              out_last_q     <= SLOT_LAST_EN && (pos_d == LAST_POS);
            end
          end
        end
`ifdef SORT_RESULT_READER_CHECKSUM_EN
        CSUM: begin
          if (rise) begin
            overrun_q <= 1'b1;
          end
          if (accept) begin
            state_q        <= IDLE;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_index_q    <= '0;
            out_position_q <= '0;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_index    = out_index_q;
  assign out_position = out_position_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule
